// File: rtl/rns_cmp_pkg.sv
// -----------------------------------------------------------------------------
// rns_cmp_pkg
// Shared definitions for the RNS magnitude comparator:
//   - residue base width RNS_N and the moduli m1=2^N-1, m2=2^N, m3=2^N+1
//   - dynamic range M = 2^N*(2^2N-1) and the binary word width W = 3N
//   - modular add/sub helpers for mod (2^N-1) and mod (2^N+1)
//   - the per-stage payload struct {v1, v2, v3, const, err}
// Optional feature macro: RNS_CMP_WINDOW_EN adds the upper window bound to the
// payload.
// The struct widths follow RNS_N, so the N parameter of the modules that
// import this package must equal RNS_N.
// -----------------------------------------------------------------------------
package rns_cmp_pkg;

    localparam int RNS_N = 3;

    typedef logic [RNS_N-1:0]   res_t;   // residue mod m1 / m2
    typedef logic [RNS_N:0]     res3_t;  // residue mod m3 (one extra bit)
    typedef logic [3*RNS_N-1:0] word_t;  // reconstructed binary value

    function automatic int unsigned mod_m1();
        return (32'd1 << RNS_N) - 32'd1;
    endfunction

    function automatic int unsigned mod_m2();
        return 32'd1 << RNS_N;
    endfunction

    function automatic int unsigned mod_m3();
        return (32'd1 << RNS_N) + 32'd1;
    endfunction

    function automatic int unsigned range_m();
        return mod_m2() * (mod_m2() * mod_m2() - 32'd1);
    endfunction

    function automatic int unsigned word_w();
        return 32'd3 * RNS_N;
    endfunction

    // Operands must already lie in [0, m1-1]; one conditional subtract suffices.
    function automatic res_t add_m1(input res_t a, input res_t b);
        int unsigned d;
        d = 32'(a) + 32'(b);
        if (d >= mod_m1()) begin
            d = d - mod_m1();
        end
        return res_t'(d);
    endfunction

    function automatic res_t sub_m1(input res_t a, input res_t b);
        int unsigned d;
        d = 32'(a) + mod_m1() - 32'(b);
        if (d >= mod_m1()) begin
            d = d - mod_m1();
        end
        return res_t'(d);
    endfunction

    function automatic res3_t add_m3(input res3_t a, input res3_t b);
        int unsigned d;
        d = 32'(a) + 32'(b);
        if (d >= mod_m3()) begin
            d = d - mod_m3();
        end
        return res3_t'(d);
    endfunction

    function automatic res3_t sub_m3(input res3_t a, input res3_t b);
        int unsigned d;
        d = 32'(a) + mod_m3() - 32'(b);
        if (d >= mod_m3()) begin
            d = d - mod_m3();
        end
        return res3_t'(d);
    endfunction

    // Multiply by 2^(N-1) mod m3 as N-1 modular doublings. 2^(N-1) is the
    // negated inverse of 2 mod (2^N+1), which is what the MRC step needs.
    function automatic res3_t scale_m3(input res3_t a);
        res3_t r;
        r = a;
        for (int i = 0; i < RNS_N - 1; i++) begin
            r = add_m3(r, r);
        end
        return r;
    endfunction

    typedef struct packed {
        res_t  v1;    // first mixed-radix digit (= x2)
        res_t  v2;    // second digit, mod m1
        res3_t v3;    // third digit mod m3; carries raw x3 between S1 and S2
        word_t cval;  // lower compare constant tagged at accept
`ifdef RNS_CMP_WINDOW_EN
        word_t chi;   // upper window bound tagged at accept
`endif
        logic  err;   // x3 was out of range
    } stage_t;

    localparam int STAGE_W = $bits(stage_t);

endpackage

// File: rtl/rns_mrc_stage_pipe.sv
// -----------------------------------------------------------------------------
// rns_mrc_stage_pipe
// Two-stage mixed-radix digit generator (S1, S2) with a shared stall enable.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   en                advance enable; both stages hold when low
//   in_valid          operand valid, captured on an enabled edge
//   a1, a2, a3        residues mod 2^N-1, 2^N, 2^N+1
//   cval              compare constant to tag onto the operand
//   chi               upper window bound (only with RNS_CMP_WINDOW_EN)
//   out_valid         S2 holds a valid payload
//   out_data          S2 payload, packed stage_t
// Optional feature macro: RNS_CMP_WINDOW_EN.
// -----------------------------------------------------------------------------
module rns_mrc_stage_pipe
    import rns_cmp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic [RNS_N-1:0]     a1,
    input  logic [RNS_N-1:0]     a2,
    input  logic [RNS_N:0]       a3,
    input  logic [3*RNS_N-1:0]   cval,
`ifdef RNS_CMP_WINDOW_EN
    input  logic [3*RNS_N-1:0]   chi,
`endif
    output logic                 out_valid,
    output logic [STAGE_W-1:0]   out_data
);

    res_t   x1_s;
    res_t   x2_s;
    stage_t s1_s;
    stage_t s1_r;
    stage_t s2_s;
    stage_t s2_r;
    logic   s1_valid_r;
    logic   s2_valid_r;

    // S1: normalise residues, first two digits and the range error flag.
    always_comb begin
        s1_s = '0;
        // All-ones is the second encoding of zero mod 2^N-1.
        if (a1 == {RNS_N{1'b1}}) begin
            x1_s = {RNS_N{1'b0}};
        end else begin
            x1_s = a1;
        end
        // x2 must be reduced into the m1 range before the m1 subtraction.
        if (a2 == {RNS_N{1'b1}}) begin
            x2_s = {RNS_N{1'b0}};
        end else begin
            x2_s = a2;
        end
        s1_s.v1   = a2;
        s1_s.v2   = sub_m1(x1_s, x2_s);
        s1_s.v3   = a3;
        s1_s.cval = cval;
`ifdef RNS_CMP_WINDOW_EN
        s1_s.chi  = chi;
`endif
        s1_s.err  = (a3 > {1'b1, {RNS_N{1'b0}}});
    end

    // S2: third digit v3 = ((v1 - x3) - v2) * 2^(N-1) mod m3.
    always_comb begin
        s2_s    = s1_r;
        s2_s.v3 = scale_m3(sub_m3(sub_m3({1'b0, s1_r.v1}, s1_r.v3),
                                  {1'b0, s1_r.v2}));
    end

    // Stage registers, advancing together when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
            s1_r       <= '0;
            s2_r       <= '0;
        end else if (en) begin
            s1_valid_r <= in_valid;
            s1_r       <= s1_s;
            s2_valid_r <= s1_valid_r;
            s2_r       <= s2_s;
        end
    end

    assign out_valid = s2_valid_r;
    assign out_data  = s2_r;

endmodule

// File: rtl/rns_compare_pipe.sv
// -----------------------------------------------------------------------------
// rns_compare_pipe
// Pipelined magnitude comparator for RNS operands in {2^N-1, 2^N, 2^N+1}.
// Each accepted operand is converted by mixed-radix conversion and compared
// against the constant held when it was accepted. Latency 3, throughput 1.
// Ports:
//   clk_in, rst_in          clock, asynchronous active-high reset
//   in_valid_in/ready_out   operand handshake
//   a1_in, a2_in, a3_in     residues mod 2^N-1, 2^N, 2^N+1
//   const_wr_in/data_in     load lower compare constant
//   out_valid_out/ready_in  result handshake
//   res_le/eq/gr_out        operand <, ==, > constant
//   err_out                 a3 residue exceeded 2^N
//   const_hi_wr_in/data_in  load upper window bound (RNS_CMP_WINDOW_EN)
//   res_win_out             const <= X <= const_hi   (RNS_CMP_WINDOW_EN)
// Optional feature macro: RNS_CMP_WINDOW_EN.
// -----------------------------------------------------------------------------
module rns_compare_pipe
    import rns_cmp_pkg::*;
#(
    parameter int N          = RNS_N,
    parameter int CONST_INIT = 10
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    input  logic [N-1:0]     a1_in,
    input  logic [N-1:0]     a2_in,
    input  logic [N:0]       a3_in,
    input  logic             const_wr_in,
    input  logic [3*N-1:0]   const_data_in,
    output logic             out_valid_out,
    input  logic             out_ready_in,
    output logic             res_le_out,
    output logic             res_eq_out,
    output logic             res_gr_out,
    output logic             err_out
`ifdef RNS_CMP_WINDOW_EN
    ,
    input  logic             const_hi_wr_in,
    input  logic [3*N-1:0]   const_hi_data_in,
    output logic             res_win_out
`endif
);

    logic               adv_s;
    word_t              const_r;
    logic               s2_valid_s;
    logic [STAGE_W-1:0] s2_bits_s;
    stage_t             s2_s;
    word_t              hi_s;
    word_t              x_s;
    logic               le_s;
    logic               eq_s;
    logic               gr_s;
    logic               win_s;
    logic               out_valid_r;
    logic               le_r;
    logic               eq_r;
    logic               gr_r;
    logic               err_r;
`ifdef RNS_CMP_WINDOW_EN
    word_t              const_hi_r;
    logic               win_r;
`endif

    // The whole pipe moves whenever the output slot is free or being drained.
    assign adv_s        = !out_valid_r | out_ready_in;
    assign in_ready_out = adv_s;

    // Compare constant register(s); an operand accepted on the write edge
    // still sees the old value because the S1 capture reads const_r.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            const_r <= word_t'(CONST_INIT);
        end else if (const_wr_in) begin
            const_r <= const_data_in;
        end
    end

`ifdef RNS_CMP_WINDOW_EN
    // Upper window bound register, reset to the top of the range.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            const_hi_r <= word_t'(range_m() - 32'd1);
        end else if (const_hi_wr_in) begin
            const_hi_r <= const_hi_data_in;
        end
    end
`endif

    rns_mrc_stage_pipe u_mrc (
        .clk       (clk_in),
        .rst       (rst_in),
        .en        (adv_s),
        .in_valid  (in_valid_in),
        .a1        (a1_in),
        .a2        (a2_in),
        .a3        (a3_in),
        .cval      (const_r),
`ifdef RNS_CMP_WINDOW_EN
        .chi       (const_hi_r),
`endif
        .out_valid (s2_valid_s),
        .out_data  (s2_bits_s)
    );

    assign s2_s = s2_bits_s;

    // S3: X = v1 + 2^N*(v2 + m1*v3) and the compare against the tagged bounds.
    always_comb begin
        hi_s  = word_t'(s2_s.v2) + word_t'(mod_m1()) * word_t'(s2_s.v3);
        x_s   = word_t'(s2_s.v1) + (hi_s << RNS_N);
        le_s  = 1'b0;
        eq_s  = 1'b0;
        gr_s  = 1'b0;
        win_s = 1'b0;
        if (s2_s.err) begin
            le_s  = 1'b0;
            eq_s  = 1'b0;
            gr_s  = 1'b0;
            win_s = 1'b0;
        end else begin
            le_s  = (x_s <  s2_s.cval);
            eq_s  = (x_s == s2_s.cval);
            gr_s  = (x_s >  s2_s.cval);
`ifdef RNS_CMP_WINDOW_EN
            win_s = (x_s >= s2_s.cval) && (x_s <= s2_s.chi);
`else
            win_s = 1'b0;
`endif
        end
    end

    // Output register; holds its contents while stalled.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            out_valid_r <= 1'b0;
            le_r        <= 1'b0;
            eq_r        <= 1'b0;
            gr_r        <= 1'b0;
            err_r       <= 1'b0;
`ifdef RNS_CMP_WINDOW_EN
            win_r       <= 1'b0;
`endif
        end else if (adv_s) begin
            out_valid_r <= s2_valid_s;
            if (s2_valid_s) begin
                le_r  <= le_s;
                eq_r  <= eq_s;
                gr_r  <= gr_s;
                err_r <= s2_s.err;
`ifdef RNS_CMP_WINDOW_EN
                win_r <= win_s;
`endif
            end else begin
                le_r  <= 1'b0;
                eq_r  <= 1'b0;
                gr_r  <= 1'b0;
                err_r <= 1'b0;
`ifdef RNS_CMP_WINDOW_EN
                win_r <= 1'b0;
`endif
            end
        end
    end

    assign out_valid_out = out_valid_r;
    assign res_le_out    = le_r;
    assign res_eq_out    = eq_r;
    assign res_gr_out    = gr_r;
    assign err_out       = err_r;
`ifdef RNS_CMP_WINDOW_EN
    assign res_win_out   = win_r;
`else
    // win_s only feeds the optional window output.
    logic unused_win_s;
    assign unused_win_s = win_s;
`endif

endmodule
